// File: rtl/uart_pkg.sv
// Shared UART constants: divisor widths, oversampling ratio, reset divisor.
// Reset divisor targets 115200 baud at 16x oversampling from a 50 MHz core clock.
// No logic; types and constants only.
package uart_pkg;

    localparam int UART_DIV_INT_W     = 16;
    localparam int UART_DIV_FRAC_W    = 4;
    localparam int UART_OVERSAMPLING  = 16;
    localparam int UART_RST_DIV_INT   = 27;
    localparam int UART_RST_DIV_FRAC  = 2;

    typedef struct packed {
        logic [UART_DIV_INT_W-1:0]  div_int;
        logic [UART_DIV_FRAC_W-1:0] div_frac;
    } baud_div_t;

endpackage

// File: rtl/baud_gen_frac.sv
// Fractional baud generator: os tick every DIV_INT + DIV_FRAC/2^FRAC_W clocks, bit tick every OVERSAMPLING os ticks.
// Ticks decode registered state with no extra latency; a loaded divisor takes effect on the next os tick.
// No backpressure; i_en low freezes the counters and suppresses ticks.
module baud_gen_frac
    import uart_pkg::*;
#(
    parameter int INT_W        = UART_DIV_INT_W,
    parameter int FRAC_W       = UART_DIV_FRAC_W,
    parameter int OVERSAMPLING = UART_OVERSAMPLING,
    parameter int RST_DIV_INT  = UART_RST_DIV_INT,
    parameter int RST_DIV_FRAC = UART_RST_DIV_FRAC
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_en,
    input  logic [INT_W-1:0]                i_div_int,
    input  logic [FRAC_W-1:0]               i_div_frac,
    input  logic                            i_div_load,
    input  logic                            i_restart,
    output logic                            o_os_tick,
    output logic                            o_bit_tick,
    output logic [$clog2(OVERSAMPLING)-1:0] o_os_idx
);

    localparam int IDX_W = $clog2(OVERSAMPLING);

    typedef struct packed {
        logic [INT_W-1:0]  div_int;
        logic [FRAC_W-1:0] div_frac;
    } div_t;

    localparam div_t RST_DIV = '{div_int: INT_W'(RST_DIV_INT), div_frac: FRAC_W'(RST_DIV_FRAC)};

    // Reload value for the down-counter; a divisor of 0 runs exactly like 1.
    function automatic logic [INT_W-1:0] eff_m1(input logic [INT_W-1:0] d);
        return (d == '0) ? '0 : d - INT_W'(1);
    endfunction

    div_t               act_q;
    div_t               shd_q;
    div_t               shd_nxt;
    div_t               tick_div;
    logic               pend_q;
    logic [INT_W-1:0]   cnt_q;
    logic [FRAC_W-1:0]  acc_q;
    logic [IDX_W-1:0]   idx_q;
    logic               cnt_zero;
    logic               os_tick;
    logic               idx_wrap;
    logic [FRAC_W:0]    frac_sum;
    logic [INT_W-1:0]   reload;

    always_comb begin
        shd_nxt  = i_div_load ? div_t'{div_int: i_div_int, div_frac: i_div_frac} : shd_q;
        tick_div = pend_q ? shd_q : act_q;
        cnt_zero = (cnt_q == '0);
        os_tick  = i_en & cnt_zero & ~i_restart & ~i_rst;
        idx_wrap = (idx_q == IDX_W'(OVERSAMPLING - 1));
        frac_sum = {1'b0, acc_q} + {1'b0, tick_div.div_frac};
        // The fractional carry stretches this period by one clock, keeping the long-run average exact.
        reload   = eff_m1(tick_div.div_int) + INT_W'(frac_sum[FRAC_W]);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            act_q  <= RST_DIV;
            shd_q  <= RST_DIV;
            pend_q <= 1'b0;
            cnt_q  <= eff_m1(RST_DIV.div_int);
            acc_q  <= '0;
            idx_q  <= '0;
        end else begin
            shd_q <= shd_nxt;
            if (i_restart) begin
                if (pend_q || i_div_load) begin
                    act_q <= shd_nxt;
                    cnt_q <= eff_m1(shd_nxt.div_int);
                end else begin
                    cnt_q <= eff_m1(act_q.div_int);
                end
                pend_q <= 1'b0;
                acc_q  <= '0;
                idx_q  <= '0;
            end else if (i_en) begin
                if (cnt_zero) begin
                    act_q  <= tick_div;
                    acc_q  <= frac_sum[FRAC_W-1:0];
                    cnt_q  <= reload;
                    idx_q  <= idx_wrap ? '0 : idx_q + IDX_W'(1);
                    pend_q <= i_div_load;
                end else begin
                    cnt_q <= cnt_q - INT_W'(1);
                    if (i_div_load) begin
                        pend_q <= 1'b1;
                    end
                end
            end else if (pend_q) begin
                // Frozen: there is no tick to wait for, so apply the divisor now.
                act_q  <= shd_q;
                cnt_q  <= eff_m1(shd_q.div_int);
                pend_q <= i_div_load;
            end else if (i_div_load) begin
                pend_q <= 1'b1;
            end
        end
    end

    assign o_os_tick  = os_tick;
    assign o_bit_tick = os_tick & idx_wrap;
    assign o_os_idx   = idx_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Directed bench for baud_gen_frac; tick times are recorded as the clock edge
// that consumes the tick, so a period is the difference of two such edges.
module tb_baud_gen_frac;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_en;
    logic [15:0] i_div_int;
    logic [3:0]  i_div_frac;
    logic        i_div_load;
    logic        i_restart;
    logic        o_os_tick;
    logic        o_bit_tick;
    logic [3:0]  o_os_idx;

    baud_gen_frac dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_en       (i_en),
        .i_div_int  (i_div_int),
        .i_div_frac (i_div_frac),
        .i_div_load (i_div_load),
        .i_restart  (i_restart),
        .o_os_tick  (o_os_tick),
        .o_bit_tick (o_bit_tick),
        .o_os_idx   (o_os_idx)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_tick(output int e, output int idx, output int bt);
        bit found;
        found = 1'b0;
        e = -1; idx = -1; bt = -1;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge i_clk);
            if (o_os_tick === 1'b1) begin
                e = cyc + 1; idx = int'(o_os_idx); bt = int'(o_bit_tick);
                found = 1'b1;
            end
        end
        if (!found) check("tick_timeout", 0, 1);
    endtask

    // Called at a negedge; returns at the next negedge with the pulse dropped.
    task automatic load_pulse(input int di, input int df, input bit rs, output int r);
        i_div_int  = 16'(di);
        i_div_frac = 4'(df);
        i_div_load = 1'b1;
        i_restart  = rs;
        r = cyc + 1;
        @(negedge i_clk);
        i_div_load = 1'b0;
        i_restart  = 1'b0;
    endtask

    int e, pe, idx, bt, lb, r, rel, nt, span;

    initial begin
        i_rst = 1'b1; i_en = 1'b1; i_div_int = '0; i_div_frac = '0;
        i_div_load = 1'b0; i_restart = 1'b0;
        repeat (3) @(negedge i_clk);
        check("rst_os_tick", int'(o_os_tick), 0);
        check("rst_bit_tick", int'(o_bit_tick), 0);
        check("rst_os_idx", int'(o_os_idx), 0);

        // Reset divisor 27.2: acc gains 2/16 per tick, carry on every 8th tick.
        rel = cyc; i_rst = 1'b0;
        lb = -1; pe = 0;
        for (int k = 1; k <= 48; k++) begin
            wait_tick(e, idx, bt);
            if (k == 1) check("t1_first", e - rel, 27);
            else        check("t1_period", e - pe, ((k - 1) % 8 == 0) ? 28 : 27);
            check("t1_idx", idx, (k - 1) % 16);
            check("t1_bit", bt, ((k - 1) % 16 == 15) ? 1 : 0);
            if (bt == 1) begin
                if (lb >= 0) check("t1_bit_period", e - lb, 434);
                lb = e;
            end
            pe = e;
        end

        // Load 4.0 together with restart: restart uses the new divisor.
        load_pulse(4, 0, 1'b1, r);
        lb = -1; pe = r;
        for (int k = 1; k <= 40; k++) begin
            wait_tick(e, idx, bt);
            check("t2_period", e - pe, 4);
            check("t2_idx", idx, (k - 1) % 16);
            if (bt == 1) begin
                if (lb >= 0) check("t2_bit_period", e - lb, 64);
                lb = e;
            end
            pe = e;
        end

        // 4.8: periods 4,4,5,4,5,... ; 160 ticks span 720 +/- 1 clocks.
        load_pulse(4, 8, 1'b0, r);
        i_restart = 1'b1; r = cyc + 1;
        @(negedge i_clk);
        i_restart = 1'b0;
        pe = r;
        for (int k = 1; k <= 160; k++) begin
            wait_tick(e, idx, bt);
            if (k <= 6) check("t3_period", e - pe, (k >= 2 && (k - 1) % 2 == 0) ? 5 : 4);
            pe = e;
        end
        span = e - r;
        check("t3_span", (span >= 719 && span <= 721) ? 720 : span, 720);

        // Running at 10, load 3 mid-period: current period stays 10.
        load_pulse(10, 0, 1'b1, r);
        wait_tick(e, idx, bt);
        check("t4_first", e - r, 10);
        pe = e;
        @(negedge i_clk);
        load_pulse(3, 0, 1'b0, r);
        wait_tick(e, idx, bt);
        check("t4_old_period", e - pe, 10);
        pe = e;
        for (int k = 0; k < 2; k++) begin
            wait_tick(e, idx, bt);
            check("t4_new_period", e - pe, 3);
            pe = e;
        end

        // Restart exactly on the os tick carrying idx 7.
        load_pulse(4, 0, 1'b1, r);
        for (int k = 0; k < 20 && idx != 7; k++) wait_tick(e, idx, bt);
        check("t5_found_idx7", idx, 7);
        i_restart = 1'b1;
        #1;
        check("t5_restart_no_tick", int'(o_os_tick), 0);
        r = cyc + 1;
        @(negedge i_clk);
        i_restart = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            wait_tick(e, idx, bt);
            if (k == 1) begin
                check("t5_first", e - r, 4);
                check("t5_first_idx", idx, 0);
            end
            check("t5_bit", bt, (k == 16) ? 1 : 0);
        end

        // Freeze for 50 edges right after a tick: period resumes where it stopped.
        wait_tick(e, idx, bt);
        pe = e;
        @(negedge i_clk);
        i_en = 1'b0; nt = 0;
        repeat (50) begin
            @(negedge i_clk);
            if (o_os_tick === 1'b1) nt++;
        end
        check("t6_no_ticks", nt, 0);
        check("t6_idx_held", int'(o_os_idx), 1);
        i_en = 1'b1;
        wait_tick(e, idx, bt);
        check("t6_resume", e - pe, 54);
        check("t6_resume_idx", idx, 1);

        // Reset mid-period: outputs clear at once, divisor back to 27.2.
        repeat (2) @(negedge i_clk);
        i_rst = 1'b1;
        #1;
        check("t6_rst_tick", int'(o_os_tick), 0);
        check("t6_rst_bit", int'(o_bit_tick), 0);
        check("t6_rst_idx", int'(o_os_idx), 0);
        @(negedge i_clk);
        rel = cyc; i_rst = 1'b0;
        #1;
        check("t6_release_tick", int'(o_os_tick), 0);
        for (int k = 1; k <= 9; k++) begin
            wait_tick(e, idx, bt);
            if (k == 1) check("t6_first", e - rel, 27);
            else        check("t6_period", e - pe, ((k - 1) % 8 == 0) ? 28 : 27);
            check("t6_idx", idx, k - 1);
            pe = e;
        end

        // Divisors 0 and 1: tick every cycle.
        for (int d = 0; d <= 1; d++) begin
            i_div_int = 16'(d); i_div_frac = '0; i_div_load = 1'b1; i_restart = 1'b1;
            @(negedge i_clk);
            i_div_load = 1'b0; i_restart = 1'b0;
            for (int k = 0; k < 6; k++) begin
                if (k > 0) @(negedge i_clk);
                #1;
                check("t7_every_cycle", int'(o_os_tick), 1);
                check("t7_idx", int'(o_os_idx), k);
            end
            @(negedge i_clk);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
